ip_packet_rx: RTL and testbench
===============================

Name: ip_packet_rx

Overview:
Receive-side counterpart of the accelerator's IP transmit path. Accepts a byte stream from the MAC RX AXI-Stream interface and parses the Ethernet header (14 B), IPv4 header (20 B) and 2-byte payload carrying a 10-bit message. Validates addressing, type, length and header checksum, then presents sender MAC/IP and message to the accelerator through a valid/accept handshake. Non-matching or malformed frames are discarded.

Parameters:
AXI_S_DATA_WIDTH, 8, MAC stream byte width (fixed 8)
IP_ADDR_WIDTH, 32, IPv4 address width
MAC_ADDR_WIDTH, 48, MAC address width
ACCEL_DATA_WIDTH, 10, message width

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous, active-high reset
ACCELERATOR_IP_ADDRESS  in  32  local IP; must match IP destination
ACCELERATOR_MAC_ADDRESS  in  48  local MAC; must match Ethernet destination (or broadcast)
MAC_DATA_IN  in  8  RX stream byte
MAC_DATA_VALID  in  1  RX tvalid
MAC_DATA_READY  out  1  RX tready
MAC_DATA_LAST  in  1  RX tlast
MAC_DATA_TUSER  in  1  RX tuser; high on last beat = bad frame (FCS error)
SENDER_IP_ADDRESS  out  32  IP source of accepted frame
SENDER_MAC_ADDRESS  out  48  Ethernet source of accepted frame
RECEIVED_MESSAGE  out  10  payload {byte0[1:0], byte1}
MESSAGE_VALID  out  1  result available
MESSAGE_ACCEPT  in  1  accelerator consumes result
FRAME_DROPPED  out  1  one-cycle pulse per discarded frame

Behaviour:
- One clock (ACLK); ARESET synchronous active-high. Reset: state RECV_ETH_HDR, byte counter 0, checksum accumulator 0, error flag 0, all outputs 0 except MAC_DATA_READY=1. Reset mid-frame abandons the frame without a FRAME_DROPPED pulse; remaining bytes are treated as a new frame.
- Beat = MAC_DATA_VALID & MAC_DATA_READY. Counter advances only on beats.
- States:
  RECV_ETH_HDR (bytes 0-13): bytes 0-5 dest MAC, 6-11 src MAC (captured to shadow reg), 12-13 ethertype. Error if dest != ACCELERATOR_MAC_ADDRESS and != FF:FF:FF:FF:FF:FF, or ethertype != 0x0800. Byte 13 -> RECV_IP_HDR, counter 0.
  RECV_IP_HDR (bytes 0-19): byte0 must be 0x45; bytes 2-3 total length must be 22 (0x0016); bytes 12-15 src IP (shadow); bytes 16-19 must equal ACCELERATOR_IP_ADDRESS. Others ignored except in checksum. Byte 19 -> RECV_USER_DATA.
  RECV_USER_DATA (bytes 0-1): capture message; byte0[7:2] ignored. After byte1: LAST -> evaluate; else DRAIN.
  DRAIN: accept and discard MAC padding until LAST beat, then evaluate.
  HOLD_RESULT: MAC_DATA_READY=0, MESSAGE_VALID=1; on MESSAGE_ACCEPT -> RECV_ETH_HDR, READY high next cycle.
- Checksum: 17-bit one's-complement accumulation of the ten 16-bit header words (big-endian, high byte first), end-around carry folded each word. Final sum must be 0xFFFF, else error.
- Errors set a sticky flag; parsing continues until LAST so framing stays aligned (no early exit).
- Evaluate on LAST beat: if error flag, TUSER=1 on that beat, or LAST arrived before payload byte1 -> FRAME_DROPPED=1 next cycle, return to RECV_ETH_HDR, outputs unchanged. Else, next cycle: shadow regs copied to SENDER_*/RECEIVED_MESSAGE, MESSAGE_VALID=1, state HOLD_RESULT. Latency: MESSAGE_VALID one cycle after final beat.
- LAST in any header state = runt: drop as above.
- SENDER_*/RECEIVED_MESSAGE hold until next accepted frame.
- MESSAGE_ACCEPT ignored when MESSAGE_VALID=0.
- Counter 8 bits, never wraps within legal frame; DRAIN does not count.

Test Plan:
- Valid frame: dst MAC=local 02:00:00:00:00:01, src 02:00:00:00:00:AA, IP 10.0.0.5->10.0.0.1, correct checksum, payload 0x02,0x5A, LAST on byte 35 -> MESSAGE_VALID next cycle, RECEIVED_MESSAGE=0x25A, SENDER_IP=0x0A000005; ACCEPT -> READY=1 next cycle.
- Same frame, checksum byte flipped -> FRAME_DROPPED pulse, MESSAGE_VALID stays 0, prior outputs unchanged.
- Broadcast dst MAC with 24 padding bytes (60-byte frame), VALID toggled every other cycle -> message 0x25A delivered once after final pad byte.
- Dst IP 10.0.0.9 or ethertype 0x86DD -> dropped; back-to-back valid frame immediately after is accepted.
- TUSER=1 on last beat of otherwise valid frame -> dropped; LAST at IP byte 5 (runt) -> dropped, next frame parses correctly.
- ARESET asserted at IP byte 10, then full valid frame -> no drop pulse for aborted frame, new frame delivered; MESSAGE_VALID held with ACCEPT=0 for 20 cycles keeps READY=0.

Source files
------------

// File: rtl/ip_packet_rx.sv
// ip_packet_rx: receive-side parser for Ethernet/IPv4 frames carrying a 10-bit
// accelerator message. Checks addressing, ethertype, IP version/IHL, total
// length and header checksum. Good frames are presented through a
// valid/accept handshake; bad or runt frames produce a FRAME_DROPPED pulse.
//
// Handshakes: a MAC byte is consumed on a clock edge where MAC_DATA_VALID and
// MAC_DATA_READY are both high. A result is consumed on an edge where
// MESSAGE_VALID and MESSAGE_ACCEPT are both high. MESSAGE_ACCEPT has no effect
// while MESSAGE_VALID is low. MAC_DATA_READY is low while a result is held.
module ip_packet_rx #(
  parameter int AXI_S_DATA_WIDTH = 8,
  parameter int IP_ADDR_WIDTH    = 32,
  parameter int MAC_ADDR_WIDTH   = 48,
  parameter int ACCEL_DATA_WIDTH = 10
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [IP_ADDR_WIDTH-1:0]    ACCELERATOR_IP_ADDRESS,
  input  logic [MAC_ADDR_WIDTH-1:0]   ACCELERATOR_MAC_ADDRESS,
  input  logic [AXI_S_DATA_WIDTH-1:0] MAC_DATA_IN,
  input  logic                        MAC_DATA_VALID,
  output logic                        MAC_DATA_READY,
  input  logic                        MAC_DATA_LAST,
  input  logic                        MAC_DATA_TUSER,
  output logic [IP_ADDR_WIDTH-1:0]    SENDER_IP_ADDRESS,
  output logic [MAC_ADDR_WIDTH-1:0]   SENDER_MAC_ADDRESS,
  output logic [ACCEL_DATA_WIDTH-1:0] RECEIVED_MESSAGE,
  output logic                        MESSAGE_VALID,
  input  logic                        MESSAGE_ACCEPT,
  output logic                        FRAME_DROPPED,
  output logic [2:0]                  fsm_state
);

  typedef enum logic [2:0] {
    RECV_ETH_HDR   = 3'd0,
    RECV_IP_HDR    = 3'd1,
    RECV_USER_DATA = 3'd2,
    DRAIN          = 3'd3,
    HOLD_RESULT    = 3'd4
  } state_t;

  state_t state, next_state;

  logic [7:0]                  cnt;
  logic                        err;
  logic [16:0]                 csum;
  logic [7:0]                  csum_hi;
  logic [MAC_ADDR_WIDTH-1:0]   dst_mac;
  logic [MAC_ADDR_WIDTH-1:0]   src_mac_sh;
  logic [IP_ADDR_WIDTH-1:0]    src_ip_sh;
  logic [1:0]                  msg_hi;
  logic [7:0]                  msg_lo;

  logic                        beat;
  logic                        drop;
  logic                        deliver;
  logic                        evaluate;
  logic                        err_hit;
  logic [16:0]                 csum_add;
  logic [15:0]                 csum_fold;
  logic [MAC_ADDR_WIDTH-1:0]   dst_next;
  logic [7:0]                  ip_byte;

  assign MAC_DATA_READY = (state != HOLD_RESULT);
  assign MESSAGE_VALID  = (state == HOLD_RESULT);
  assign beat           = MAC_DATA_VALID & MAC_DATA_READY;
  assign fsm_state      = state;

  // One's-complement add of the current header word with end-around carry.
  assign csum_add  = {1'b0, csum[15:0]} + {1'b0, csum_hi, MAC_DATA_IN};
  assign csum_fold = csum_add[15:0] + {15'd0, csum_add[16]};
  assign dst_next  = {dst_mac[MAC_ADDR_WIDTH-9:0], MAC_DATA_IN};

  // Local IP byte expected at IP header offsets 16..19 (big-endian).
  always_comb begin
    ip_byte = ACCELERATOR_IP_ADDRESS[7:0];
    case (cnt)
      8'd16:   ip_byte = ACCELERATOR_IP_ADDRESS[31:24];
      8'd17:   ip_byte = ACCELERATOR_IP_ADDRESS[23:16];
      8'd18:   ip_byte = ACCELERATOR_IP_ADDRESS[15:8];
      default: ip_byte = ACCELERATOR_IP_ADDRESS[7:0];
    endcase
  end

  // Per-byte header checks; a hit is folded into the sticky error flag.
  always_comb begin
    err_hit = 1'b0;
    case (state)
      RECV_ETH_HDR: begin
        if (cnt == 8'd5 && dst_next != ACCELERATOR_MAC_ADDRESS &&
            dst_next != {MAC_ADDR_WIDTH{1'b1}}) err_hit = 1'b1;
        if (cnt == 8'd12 && MAC_DATA_IN != 8'h08) err_hit = 1'b1;
        if (cnt == 8'd13 && MAC_DATA_IN != 8'h00) err_hit = 1'b1;
      end
      RECV_IP_HDR: begin
        if (cnt == 8'd0 && MAC_DATA_IN != 8'h45) err_hit = 1'b1;
        if (cnt == 8'd2 && MAC_DATA_IN != 8'h00) err_hit = 1'b1;
        if (cnt == 8'd3 && MAC_DATA_IN != 8'h16) err_hit = 1'b1;
        if (cnt >= 8'd16 && MAC_DATA_IN != ip_byte) err_hit = 1'b1;
        if (cnt == 8'd19 && csum_fold != 16'hFFFF) err_hit = 1'b1;
      end
      default: err_hit = 1'b0;
    endcase
  end

  // Next-state logic: walk header/payload byte positions, decide drop/deliver on LAST.
  always_comb begin
    next_state = state;
    drop       = 1'b0;
    deliver    = 1'b0;
    evaluate   = 1'b0;
    case (state)
      RECV_ETH_HDR: begin
        if (beat) begin
          if (MAC_DATA_LAST)      drop = 1'b1;
          else if (cnt == 8'd13)  next_state = RECV_IP_HDR;
        end
      end
      RECV_IP_HDR: begin
        if (beat) begin
          if (MAC_DATA_LAST)      drop = 1'b1;
          else if (cnt == 8'd19)  next_state = RECV_USER_DATA;
        end
      end
      RECV_USER_DATA: begin
        if (beat) begin
          if (MAC_DATA_LAST) begin
            if (cnt == 8'd1) evaluate = 1'b1;
            else             drop = 1'b1;
          end else if (cnt == 8'd1) begin
            next_state = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (beat && MAC_DATA_LAST) evaluate = 1'b1;
      end
      HOLD_RESULT: begin
        if (MESSAGE_ACCEPT) next_state = RECV_ETH_HDR;
      end
      default: next_state = RECV_ETH_HDR;
    endcase
    if (evaluate) begin
      if (err || MAC_DATA_TUSER) drop = 1'b1;
      else                       deliver = 1'b1;
    end
    if (drop)         next_state = RECV_ETH_HDR;
    else if (deliver) next_state = HOLD_RESULT;
  end

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= RECV_ETH_HDR;
    else        state <= next_state;
  end

  // Byte counter, checksum, shadow capture and result registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt                <= '0;
      err                <= 1'b0;
      csum               <= '0;
      csum_hi            <= '0;
      dst_mac            <= '0;
      src_mac_sh         <= '0;
      src_ip_sh          <= '0;
      msg_hi             <= '0;
      msg_lo             <= '0;
      FRAME_DROPPED      <= 1'b0;
      SENDER_IP_ADDRESS  <= '0;
      SENDER_MAC_ADDRESS <= '0;
      RECEIVED_MESSAGE   <= '0;
    end else begin
      FRAME_DROPPED <= drop;
      if (drop || deliver) begin
        cnt  <= '0;
        err  <= 1'b0;
        csum <= '0;
      end else begin
        if (next_state != state)       cnt <= '0;
        else if (beat && state != DRAIN) cnt <= cnt + 8'd1;
        if (beat && err_hit) err <= 1'b1;
        if (beat && state == RECV_IP_HDR) begin
          if (!cnt[0]) csum_hi <= MAC_DATA_IN;
          else         csum    <= {1'b0, csum_fold};
        end
        if (beat && state == RECV_ETH_HDR && cnt < 8'd6)
          dst_mac <= dst_next;
        if (beat && state == RECV_ETH_HDR && cnt >= 8'd6 && cnt < 8'd12)
          src_mac_sh <= {src_mac_sh[MAC_ADDR_WIDTH-9:0], MAC_DATA_IN};
        if (beat && state == RECV_IP_HDR && cnt >= 8'd12 && cnt < 8'd16)
          src_ip_sh <= {src_ip_sh[IP_ADDR_WIDTH-9:0], MAC_DATA_IN};
        if (beat && state == RECV_USER_DATA && cnt == 8'd0) msg_hi <= MAC_DATA_IN[1:0];
        if (beat && state == RECV_USER_DATA && cnt == 8'd1) msg_lo <= MAC_DATA_IN;
      end
      // When LAST lands on payload byte 1 the low byte is taken straight from the bus.
      if (deliver) begin
        SENDER_IP_ADDRESS  <= src_ip_sh;
        SENDER_MAC_ADDRESS <= src_mac_sh;
        RECEIVED_MESSAGE   <= (state == RECV_USER_DATA) ? {msg_hi, MAC_DATA_IN}
                                                        : {msg_hi, msg_lo};
      end
    end
  end

endmodule

// File: tb/tb_ip_packet_rx.sv
// tb_ip_packet_rx: drives Ethernet/IPv4 frames into ip_packet_rx and compares
// the outcome of each frame with a frame-level reference model.
module tb_ip_packet_rx;

  localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] PEER_MAC  = 48'h02_00_00_00_00_AA;
  localparam logic [31:0] LOCAL_IP  = 32'h0A00_0001;
  localparam logic [31:0] PEER_IP   = 32'h0A00_0005;

  logic        clk = 1'b0;
  logic        areset;
  logic [7:0]  data;
  logic        valid, last, tuser, accept;
  logic        ready, msg_valid, dropped;
  logic [31:0] sender_ip;
  logic [47:0] sender_mac;
  logic [9:0]  message;
  logic [2:0]  fsm_state;

  logic [7:0]  frm[$];
  logic [89:0] exp_q[$];
  logic        exp_deliver;
  logic [31:0] last_ip;
  logic [47:0] last_mac;
  logic [9:0]  last_msg;
  int          n_checks = 0;
  int          n_fail = 0;
  int          drop_count = 0;
  int          exp_drops = 0;

  always #5 clk = ~clk;

  ip_packet_rx dut (
    .ACLK(clk), .ARESET(areset),
    .ACCELERATOR_IP_ADDRESS(LOCAL_IP), .ACCELERATOR_MAC_ADDRESS(LOCAL_MAC),
    .MAC_DATA_IN(data), .MAC_DATA_VALID(valid), .MAC_DATA_READY(ready),
    .MAC_DATA_LAST(last), .MAC_DATA_TUSER(tuser),
    .SENDER_IP_ADDRESS(sender_ip), .SENDER_MAC_ADDRESS(sender_mac),
    .RECEIVED_MESSAGE(message), .MESSAGE_VALID(msg_valid),
    .MESSAGE_ACCEPT(accept), .FRAME_DROPPED(dropped), .fsm_state(fsm_state)
  );

  always @(negedge clk) if (dropped) drop_count++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Build a frame into frm; checksum computed over the header per IPv4 rules.
  task automatic build_frame(input logic [47:0] dst, input logic [47:0] smac,
                             input logic [15:0] etype, input logic [31:0] sip,
                             input logic [31:0] dip, input logic [15:0] tlen,
                             input logic [7:0] ver, input logic [7:0] m0,
                             input logic [7:0] m1, input int pad,
                             input logic [15:0] csum_xor);
    logic [7:0]  hdr[20];
    logic [31:0] s;
    logic [15:0] c;
    frm.delete();
    for (int i = 5; i >= 0; i--) frm.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(smac[8*i +: 8]);
    frm.push_back(etype[15:8]);
    frm.push_back(etype[7:0]);
    hdr[0] = ver;               hdr[1] = 8'h00;
    hdr[2] = tlen[15:8];        hdr[3] = tlen[7:0];
    hdr[4] = 8'($urandom_range(0, 255)); hdr[5] = 8'($urandom_range(0, 255));
    hdr[6] = 8'h40;             hdr[7] = 8'h00;
    hdr[8] = 8'h40;             hdr[9] = 8'h11;
    hdr[10] = 8'h00;            hdr[11] = 8'h00;
    for (int i = 0; i < 4; i++) hdr[12+i] = sip[31-8*i -: 8];
    for (int i = 0; i < 4; i++) hdr[16+i] = dip[31-8*i -: 8];
    s = 32'd0;
    for (int w = 0; w < 10; w++) s = s + {16'd0, hdr[2*w], hdr[2*w+1]};
    while (s > 32'h0000_FFFF) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    c = ~s[15:0] ^ csum_xor;
    hdr[10] = c[15:8];
    hdr[11] = c[7:0];
    for (int i = 0; i < 20; i++) frm.push_back(hdr[i]);
    frm.push_back(m0);
    frm.push_back(m1);
    for (int i = 0; i < pad; i++) frm.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference model: decide the fate of the frame in frm from the frame rules.
  task automatic model_frame(input logic tu);
    logic [47:0] d, sm;
    logic [31:0] dip, sip, s;
    logic        ok;
    ok = (frm.size() >= 36) && !tu;
    if (frm.size() >= 36) begin
      d = '0; sm = '0; dip = '0; sip = '0;
      for (int i = 0; i < 6; i++) d = {d[39:0], frm[i]};
      for (int i = 6; i < 12; i++) sm = {sm[39:0], frm[i]};
      for (int i = 26; i < 30; i++) sip = {sip[23:0], frm[i]};
      for (int i = 30; i < 34; i++) dip = {dip[23:0], frm[i]};
      if (d != LOCAL_MAC && d != BCAST_MAC) ok = 1'b0;
      if ({frm[12], frm[13]} != 16'h0800) ok = 1'b0;
      if (frm[14] != 8'h45) ok = 1'b0;
      if ({frm[16], frm[17]} != 16'd22) ok = 1'b0;
      if (dip != LOCAL_IP) ok = 1'b0;
      s = 32'd0;
      for (int w = 0; w < 10; w++) s = s + {16'd0, frm[14+2*w], frm[15+2*w]};
      while (s > 32'h0000_FFFF) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      if (s != 32'h0000_FFFF) ok = 1'b0;
      if (ok) exp_q.push_back({sip, sm, frm[34][1:0], frm[35]});
    end
    if (!ok) exp_drops++;
    exp_deliver = ok;
  endtask

  // Drive frm as a byte stream; returns #1 after the final beat's edge.
  task automatic send_frame(input logic tu, input logic gap, input logic no_last);
    int w;
    for (int i = 0; i < frm.size(); i++) begin
      if (gap) begin
        valid = 1'b0;
        @(posedge clk); #1;
      end
      data  = frm[i];
      valid = 1'b1;
      last  = (i == frm.size() - 1) && !no_last;
      tuser = last ? tu : 1'b0;
      w = 0;
      while (!ready && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      if (!ready) begin
        n_checks++; n_fail++;
        $display("FAIL ready_timeout: byte %0d ready=%b required 1", i, ready);
      end
      @(posedge clk); #1;
    end
    valid = 1'b0; last = 1'b0; tuser = 1'b0;
  endtask

  // Check the cycle after the final beat, then complete the result handshake.
  task automatic check_outcome(input int hold);
    logic [89:0] e;
    int          bad;
    n_checks++;
    if (msg_valid !== exp_deliver) begin
      n_fail++; $display("FAIL msg_valid: got %b expected %b", msg_valid, exp_deliver);
    end
    n_checks++;
    if (dropped !== !exp_deliver) begin
      n_fail++; $display("FAIL frame_dropped: got %b expected %b", dropped, !exp_deliver);
    end
    if (exp_deliver) begin
      e = exp_q.pop_front();
      {last_ip, last_mac, last_msg} = e;
    end
    n_checks++;
    if (message !== last_msg || sender_ip !== last_ip || sender_mac !== last_mac) begin
      n_fail++;
      $display("FAIL outputs: got msg=%h ip=%h mac=%h expected msg=%h ip=%h mac=%h",
               message, sender_ip, sender_mac, last_msg, last_ip, last_mac);
    end
    if (exp_deliver) begin
      bad = 0;
      data = 8'hEE; valid = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        if (ready !== 1'b0 || msg_valid !== 1'b1) bad++;
      end
      n_checks++;
      if (ready !== 1'b0 || bad != 0) begin
        n_fail++; $display("FAIL hold: ready=%b bad_cycles=%0d expected ready 0", ready, bad);
      end
      valid = 1'b0; accept = 1'b1;
      @(posedge clk); #1;
      accept = 1'b0;
      n_checks++;
      if (ready !== 1'b1 || msg_valid !== 1'b0) begin
        n_fail++; $display("FAIL accept: ready=%b valid=%b expected 1/0", ready, msg_valid);
      end
    end
  endtask

  task automatic run_frame(input logic tu, input logic gap, input int hold);
    model_frame(tu);
    send_frame(tu, gap, 1'b0);
    check_outcome(hold);
  endtask

  task automatic test_reset;
    areset = 1'b1; data = '0; valid = 1'b0; last = 1'b0; tuser = 1'b0; accept = 1'b0;
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    @(posedge clk); #1;
    last_ip = '0; last_mac = '0; last_msg = '0;
    n_checks++;
    if (ready !== 1'b1 || msg_valid !== 1'b0 || dropped !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: ready=%b valid=%b drop=%b expected 1/0/0",
                         ready, msg_valid, dropped);
    end
    n_checks++;
    if (message !== 10'd0 || sender_ip !== 32'd0 || sender_mac !== 48'd0) begin
      n_fail++; $display("FAIL reset_data: msg=%h ip=%h mac=%h expected 0", message,
                         sender_ip, sender_mac);
    end
  endtask

  task automatic test_valid_frame;
    build_frame(LOCAL_MAC, PEER_MAC, 16'h0800, PEER_IP, LOCAL_IP, 16'd22, 8'h45,
                8'h02, 8'h5A, 0, 16'h0000);
    run_frame(1'b0, 1'b0, 2);
    n_checks++;
    if (last_msg !== 10'h25A || last_ip !== 32'h0A00_0005) begin
      n_fail++; $display("FAIL plan_msg: got %h/%h expected 25a/0a000005", last_msg, last_ip);
    end
  endtask

  task automatic test_bad_checksum;
    build_frame(LOCAL_MAC, PEER_MAC, 16'h0800, 32'h0A00_0077, LOCAL_IP, 16'd22, 8'h45,
                8'h03, 8'h11, 0, 16'h0100);
    accept = 1'b1;
    run_frame(1'b0, 1'b0, 0);
    accept = 1'b0;
  endtask

  task automatic test_broadcast_padded;
    build_frame(BCAST_MAC, PEER_MAC, 16'h0800, PEER_IP, LOCAL_IP, 16'd22, 8'h45,
                8'h02, 8'h5A, 24, 16'h0000);
    run_frame(1'b0, 1'b1, 1);
  endtask

  task automatic test_back_to_back;
    build_frame(LOCAL_MAC, PEER_MAC, 16'h0800, PEER_IP, 32'h0A00_0009, 16'd22, 8'h45,
                8'h01, 8'h23, 0, 16'h0000);
    run_frame(1'b0, 1'b0, 0);
    build_frame(LOCAL_MAC, PEER_MAC, 16'h86DD, PEER_IP, LOCAL_IP, 16'd22, 8'h45,
                8'h01, 8'h23, 0, 16'h0000);
    run_frame(1'b0, 1'b0, 0);
    build_frame(LOCAL_MAC, 48'h0A_0B_0C_0D_0E_0F, 16'h0800, 32'hC0A8_0102, LOCAL_IP,
                16'd22, 8'h45, 8'hFD, 8'h77, 0, 16'h0000);
    run_frame(1'b0, 1'b0, 0);
  endtask

  task automatic test_tuser_and_runt;
    build_frame(LOCAL_MAC, PEER_MAC, 16'h0800, PEER_IP, LOCAL_IP, 16'd22, 8'h45,
                8'h02, 8'h44, 3, 16'h0000);
    run_frame(1'b1, 1'b0, 0);
    build_frame(LOCAL_MAC, PEER_MAC, 16'h0800, PEER_IP, LOCAL_IP, 16'd22, 8'h45,
                8'h02, 8'h44, 0, 16'h0000);
    while (frm.size() > 20) void'(frm.pop_back());
    run_frame(1'b0, 1'b0, 0);
    build_frame(LOCAL_MAC, PEER_MAC, 16'h0800, 32'h0A00_0042, LOCAL_IP, 16'd22, 8'h45,
                8'h01, 8'h99, 0, 16'h0000);
    run_frame(1'b0, 1'b0, 0);
  endtask

  task automatic test_midframe_reset;
    int drops_before;
    build_frame(LOCAL_MAC, PEER_MAC, 16'h0800, PEER_IP, LOCAL_IP, 16'd22, 8'h45,
                8'h02, 8'h5A, 0, 16'h0000);
    while (frm.size() > 24) void'(frm.pop_back());
    send_frame(1'b0, 1'b0, 1'b1);
    drops_before = drop_count;
    areset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    areset = 1'b0;
    last_ip = '0; last_mac = '0; last_msg = '0;
    n_checks++;
    if (message !== 10'd0 || sender_ip !== 32'd0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset: msg=%h ip=%h ready=%b expected 0/0/1", message,
                         sender_ip, ready);
    end
    build_frame(LOCAL_MAC, PEER_MAC, 16'h0800, 32'h0A00_0033, LOCAL_IP, 16'd22, 8'h45,
                8'h02, 8'h5A, 0, 16'h0000);
    run_frame(1'b0, 1'b0, 20);
    n_checks++;
    if (drop_count != drops_before) begin
      n_fail++; $display("FAIL midreset_drop: drops=%0d expected %0d", drop_count,
                         drops_before);
    end
  endtask

  task automatic test_random;
    int          kind, pad, hold;
    logic [47:0] dst;
    logic [47:0] sm;
    logic [15:0] et, tlen, cx;
    logic [31:0] dip, sip;
    logic [7:0]  ver;
    logic        tu, gap;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 13);
      dst = LOCAL_MAC; et = 16'h0800; dip = LOCAL_IP; tlen = 16'd22; ver = 8'h45;
      cx = 16'h0000; tu = 1'b0;
      if (kind == 1) dst = BCAST_MAC;
      if (kind == 2) begin
        dst[47:32] = 16'($urandom_range(0, 65535));
        dst[31:0]  = $urandom();
      end
      if (kind == 3) et = 16'h86DD;
      if (kind == 4) dip = $urandom();
      if (kind == 5) tlen = 16'($urandom_range(0, 65535));
      if (kind == 6) ver = 8'h46;
      if (kind == 7) cx = 16'(1 << $urandom_range(0, 15));
      if (kind == 9) tu = 1'b1;
      sm[47:32] = 16'($urandom_range(0, 65535));
      sm[31:0]  = $urandom();
      sip = $urandom();
      pad = $urandom_range(0, 26);
      gap = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      build_frame(dst, sm, et, sip, dip, tlen, ver, 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), pad, cx);
      if (kind == 8) begin
        int keep;
        keep = $urandom_range(1, 35);
        while (frm.size() > keep) void'(frm.pop_back());
      end
      run_frame(tu, gap, hold);
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_broadcast_padded();
    test_back_to_back();
    test_tuser_and_runt();
    test_midframe_reset();
    test_random();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (drop_count != exp_drops) begin
      n_fail++; $display("FAIL drop_total: got %0d expected %0d", drop_count, exp_drops);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL leftover_results: got %0d expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
